// File: rtl/traffic_light_ctrl.sv
// Four-phase car/pedestrian traffic light controller with one shared dwell counter.
// Define PED_EARLY_GREEN_EN to let a pending pedestrian request cut green short.
module traffic_light_ctrl #(
  parameter int T_GREEN     = 512,
  parameter int T_YELLOW    = 128,
  parameter int T_RED       = 256,
  parameter int T_WALK      = 256,
  parameter int T_MIN_GREEN = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       EN,
  input  logic       ped_req,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic       walk,
  output logic [1:0] phase,
  output logic       phase_done
);

  localparam logic [1:0] S_GREEN  = 2'b00;
  localparam logic [1:0] S_YELLOW = 2'b01;
  localparam logic [1:0] S_RED    = 2'b10;
  localparam logic [1:0] S_WALK   = 2'b11;

  localparam logic [9:0] LAST_G = 10'(T_GREEN - 1);
  localparam logic [9:0] LAST_Y = 10'(T_YELLOW - 1);
  localparam logic [9:0] LAST_R = 10'(T_RED - 1);
  localparam logic [9:0] LAST_W = 10'(T_WALK - 1);

  if (T_GREEN < 1 || T_GREEN > 1024 ||
      T_YELLOW < 1 || T_YELLOW > 1024 ||
      T_RED < 1 || T_RED > 1024 ||
      T_WALK < 1 || T_WALK > 1024 ||
      T_MIN_GREEN < 1 || T_MIN_GREEN > 1024) begin : g_bad_cfg
    $error("traffic_light_ctrl: dwell parameter out of 1..1024");
  end

  logic [1:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       ped_q, ped_d;
  logic       done_q, done_d;
  logic [9:0] last;
  logic [1:0] nxt;
  logic       leave;

  always_comb begin
    last = LAST_G;
    nxt  = S_YELLOW;
    unique case (state_q)
      S_GREEN: begin
        last = LAST_G;
        nxt  = S_YELLOW;
      end
      S_YELLOW: begin
        last = LAST_Y;
        nxt  = ped_q ? S_WALK : S_RED;
      end
      S_RED: begin
        last = LAST_R;
        nxt  = S_GREEN;
      end
      S_WALK: begin
        last = LAST_W;
        nxt  = S_GREEN;
      end
      default: begin
        last = LAST_G;
        nxt  = S_YELLOW;
      end
    endcase
  end

`ifdef PED_EARLY_GREEN_EN
  localparam logic [9:0] MIN_G = 10'(T_MIN_GREEN - 1);
  logic early;
  assign early = (state_q == S_GREEN) && ped_q &&
                 (cnt_q >= MIN_G);
`else
  logic early;
  assign early = 1'b0;
`endif

  assign leave = (cnt_q == last) || early;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q;
    done_d  = 1'b0;
    // Requests latch even while frozen; WALK itself ignores them.
    if (ped_req && state_q != S_WALK) ped_d = 1'b1;
    if (EN) begin
      if (leave) begin
        state_d = nxt;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (nxt == S_WALK) ped_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_GREEN;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      done_q  <= done_d;
    end
  end

  assign green      = (state_q == S_GREEN);
  assign yellow     = (state_q == S_YELLOW);
  assign red        = state_q[1];
  assign walk       = (state_q == S_WALK);
  assign phase      = state_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default dwell times.
// Expected cycle numbers are hand-derived; macro-dependent ones are selected below.
module tb_traffic_light_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       EN = 1'b1;
  logic       ped_req = 1'b0;
  logic       green, yellow, red, walk;
  logic [1:0] phase;
  logic       phase_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  traffic_light_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .EN         (EN),
    .ped_req    (ped_req),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .walk       (walk),
    .phase      (phase),
    .phase_done (phase_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic chk_ph(input string tag,
                        input logic [1:0] p);
    logic [3:0] lamps;
    lamps = {p == 2'd0, p == 2'd1, p[1], p == 2'd3};
    check({tag, ".phase"}, 32'(phase), 32'(p));
    check({tag, ".lamps"},
          32'({green, yellow, red, walk}), 32'(lamps));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    EN = 1'b1;
    ped_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    cyc = 0;
  endtask

  task automatic ped_pulse(input int c);
    run_to(c);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
  endtask

`ifdef PED_EARLY_GREEN_EN
  localparam int WALK1 = 256;
  localparam int WALK2 = 2048;
`else
  localparam int WALK1 = 640;
  localparam int WALK2 = 2432;
`endif

  initial begin
    int pulses;

    // Plain cycle, no requests
    do_reset();
    chk_ph("rst", 2'd0);
    check("rst.done", 32'(phase_done), 0);
    run_to(511);
    chk_ph("g511", 2'd0);
    run_to(512);
    chk_ph("y512", 2'd1);
    check("y512.done", 32'(phase_done), 1);
    run_to(513);
    check("y513.done", 32'(phase_done), 0);
    run_to(639);
    chk_ph("y639", 2'd1);
    run_to(640);
    chk_ph("r640", 2'd2);
    check("r640.done", 32'(phase_done), 1);
    run_to(895);
    chk_ph("r895", 2'd2);
    run_to(896);
    chk_ph("g896", 2'd0);
    check("g896.done", 32'(phase_done), 1);

    // Request at cycle 10
    do_reset();
    ped_pulse(10);
`ifdef PED_EARLY_GREEN_EN
    run_to(127);
    chk_ph("e127", 2'd0);
    run_to(128);
    chk_ph("e128", 2'd1);
    check("e128.done", 32'(phase_done), 1);
    do_reset();
    ped_pulse(300);
    chk_ph("e301", 2'd0);
    run_to(302);
    chk_ph("e302", 2'd1);
    check("e302.done", 32'(phase_done), 1);
`else
    run_to(511);
    chk_ph("p511", 2'd0);
    run_to(512);
    chk_ph("p512", 2'd1);
    run_to(640);
    chk_ph("p640", 2'd3);
    check("p640.done", 32'(phase_done), 1);
    run_to(895);
    chk_ph("p895", 2'd3);
    run_to(896);
    chk_ph("p896", 2'd0);
    run_to(1536);
    chk_ph("p1536", 2'd2);
`endif

    // Freeze 50 cycles mid-yellow with a request inside
    do_reset();
    run_to(560);
    EN = 1'b0;
    pulses = 0;
    while (cyc < 610) begin
      if (phase_done) pulses++;
      ped_req = (cyc == 580);
      tick();
    end
    ped_req = 1'b0;
    check("frz.pulses", 32'(pulses), 0);
    chk_ph("frz610", 2'd1);
    EN = 1'b1;
    run_to(689);
    chk_ph("frz689", 2'd1);
    run_to(690);
    chk_ph("frz690", 2'd3);
    check("frz690.done", 32'(phase_done), 1);

    // Request held through YELLOW and WALK
    do_reset();
    run_to(512);
    ped_req = 1'b1;
    run_to(640);
    chk_ph("h640", 2'd3);
    run_to(896);
    ped_req = 1'b0;
    chk_ph("h896", 2'd0);
    run_to(1407);
    chk_ph("h1407", 2'd0);
    run_to(1408);
    chk_ph("h1408", 2'd1);
    run_to(1536);
    chk_ph("h1536", 2'd2);
    ped_pulse(1600);
    run_to(WALK2 - 1);
    chk_ph("h2pre", 2'd1);
    run_to(WALK2);
    chk_ph("h2walk", 2'd3);

    // Asynchronous reset in the middle of WALK
    do_reset();
    ped_pulse(10);
    run_to(WALK1 + 100);
    chk_ph("w100", 2'd3);
    reset = 1'b1;
    #1;
    chk_ph("arst", 2'd0);
    check("arst.done", 32'(phase_done), 0);
    do_reset();
    chk_ph("ar0", 2'd0);
    run_to(128);
    chk_ph("ar128", 2'd0);
    run_to(511);
    chk_ph("ar511", 2'd0);
    run_to(512);
    chk_ph("ar512", 2'd1);
    run_to(640);
    chk_ph("ar640", 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
